// File: rtl/div_cfg_ctrl.sv
// rtl/div_cfg_ctrl.sv - divider ratio configuration front-end with quiescent switch window
module div_cfg_ctrl #(
    parameter int          HOLD_CYCLES = 4,
    parameter logic [7:0]  RESET_RATIO = 8'd1
) (
    input  logic       I_ref_clk,
    input  logic       I_rst,
    input  logic       I_enable,
    input  logic       I_cfg_valid,
    output logic       o_cfg_ready,
    input  logic       I_cfg_mode,
    input  logic [7:0] I_cfg_data,
    output logic [7:0] o_div_ratio,
    output logic       o_clk_en,
    output logic       o_busy,
    output logic       o_cfg_err
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUIESCE,
        ST_LOAD,
        ST_RESUME
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    ratio_q, ratio_d;
    logic [7:0]    staged_q, staged_d;
    logic          clk_en_q, clk_en_d;
    logic          err_q, err_d;

    logic [7:0]    map_ratio;
    logic          map_ok;
    logic [7:0]    target;
    logic          target_ok;

    always_comb begin
        map_ratio = 8'd0;
        map_ok    = 1'b1;
        case (I_cfg_data)
            8'd32:   map_ratio = 8'd1;
            8'd16:   map_ratio = 8'd2;
            8'd8:    map_ratio = 8'd4;
            8'd4:    map_ratio = 8'd8;
            default: map_ok    = 1'b0;
        endcase
        target    = I_cfg_mode ? map_ratio : I_cfg_data;
        target_ok = !I_cfg_mode || map_ok;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ratio_d  = ratio_q;
        staged_d = staged_q;
        clk_en_d = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clk_en_d = I_enable;
                if (I_cfg_valid) begin
                    if (!target_ok) begin
                        err_d = 1'b1;
                    end else if (target != ratio_q) begin
                        // Enable drops on the same edge the request is taken.
                        staged_d = target;
                        state_d  = ST_QUIESCE;
                        cnt_d    = '0;
                        clk_en_d = 1'b0;
                    end
                end
            end
            ST_QUIESCE: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LOAD: begin
                ratio_d = staged_q;
                state_d = ST_RESUME;
                cnt_d   = '0;
            end
            ST_RESUME: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge I_ref_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ratio_q  <= RESET_RATIO;
            staged_q <= RESET_RATIO;
            clk_en_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ratio_q  <= ratio_d;
            staged_q <= staged_d;
            clk_en_q <= clk_en_d;
            err_q    <= err_d;
        end
    end

    assign o_div_ratio = ratio_q;
    assign o_clk_en    = clk_en_q;
    assign o_cfg_err   = err_q;
    assign o_cfg_ready = (state_q == ST_IDLE);
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: doc/div_cfg_ctrl.md
# div_cfg_ctrl

Configuration front-end for the clock divider: accepts ratio updates over a valid/ready handshake and drives the divider's ratio and enable inputs. A prescale value can be translated into a divide ratio. Every accepted change is wrapped in a quiescent window, with the divider disabled before and after the ratio switch, so the divided clock never sees a mid-period ratio change. It sits directly upstream of the clock divider, between the register file and the divider.

## Interface
- HOLD_CYCLES, 4: number of cycles the divider stays disabled before and after the ratio switch; must be ≥1.
- RESET_RATIO, 8'd1: value of o_div_ratio after reset (bypass).
- I_ref_clk  in  1  reference clock; the only clock.
- I_rst  in  1  reset, asynchronous, active-high.
- I_enable  in  1  system request for divided clock.
- I_cfg_valid  in  1  config request valid.
- o_cfg_ready  out  1  high in IDLE only.
- I_cfg_mode  in  1  request type:
  - 0: I_cfg_data is the raw divide ratio.
  - 1: I_cfg_data is a prescale value to be mapped.
- I_cfg_data  in  8  ratio or prescale.
- o_div_ratio  out  8  to divider ratio input.
- o_clk_en  out  1  to divider enable input.
- o_busy  out  1  high while not in IDLE.
- o_cfg_err  out  1  one-cycle pulse when a prescale value is rejected.

## Operation
- Reset state, applied asynchronously on I_rst:
  - FSM = IDLE, o_div_ratio = RESET_RATIO.
  - o_clk_en = 0, o_cfg_err = 0, o_busy = 0.
  - o_cfg_ready = 1 once reset is released.
- Prescale map, used when I_cfg_mode = 1:
  - 32 → 1, 16 → 2, 8 → 4, 4 → 8.
  - Any other value is invalid.
- Direct mode (I_cfg_mode = 0): any 8-bit value is accepted, including 0 and 1, which the divider treats as bypass.
- Accept: a request is accepted on a rising edge where I_cfg_valid && o_cfg_ready. The target ratio is computed from I_cfg_data and I_cfg_mode in that cycle.
  - Invalid prescale: o_cfg_err = 1 for the next cycle only. FSM stays in IDLE, o_div_ratio is unchanged, o_cfg_ready stays 1.
  - Target equals current o_div_ratio: request is accepted as a no-op. FSM stays in IDLE and o_clk_en is not disturbed.
  - Otherwise: the target is latched into a staging register and the FSM goes to QUIESCE.
- FSM states:
  - IDLE: o_clk_en <= I_enable (registered). Handshake open.
  - QUIESCE: o_clk_en = 0. Hold counter counts HOLD_CYCLES cycles, then moves to LOAD.
  - LOAD: one cycle; o_div_ratio <= staged value. Then moves to RESUME.
  - RESUME: o_clk_en = 0. Hold counter counts HOLD_CYCLES cycles, then moves to IDLE.
- o_busy = (state != IDLE). o_cfg_ready = (state == IDLE).
- I_enable changes during QUIESCE, LOAD or RESUME are ignored; the current level is sampled on the first IDLE cycle.
- I_cfg_valid asserted while busy is not accepted. The requester must hold it until ready.
- Hold counter: width $clog2(HOLD_CYCLES+1). Cleared on every state entry; no wrap-around is possible.
- Reset mid-sequence: abort immediately to reset values. The staged ratio is discarded and o_div_ratio returns to RESET_RATIO.

## Timing
- Request accepted at edge N:
  - o_busy = 1 and o_clk_en = 0 from N+1.
  - QUIESCE occupies N+1 … N+HOLD_CYCLES.
  - LOAD occurs at N+HOLD_CYCLES+1. The new o_div_ratio is visible from N+HOLD_CYCLES+2.
  - RESUME runs through N+2·HOLD_CYCLES+1.
  - IDLE is entered, o_cfg_ready = 1 and o_busy = 0 at N+2·HOLD_CYCLES+2. o_clk_en follows I_enable one cycle later.
- o_clk_en in IDLE has exactly 1 cycle of latency from I_enable.
- o_cfg_err is asserted for exactly one cycle per rejected request. Back-to-back invalid requests give back-to-back pulses.
- All outputs are registered except o_cfg_ready and o_busy, which are decoded from the state register.

## Test plan
- Reset with I_enable = 1 → o_div_ratio = 1, o_clk_en = 0, ready = 1. One cycle after reset release, o_clk_en = 1.
- HOLD_CYCLES = 4, direct write 6 at edge N, I_enable = 1:
  - o_clk_en = 0 over N+1..N+9.
  - o_div_ratio = 6 from N+6.
  - ready = 1 at N+10; o_clk_en = 1 at N+11.
- Prescale writes 8, then 32 → o_div_ratio = 4, then 1, each taking the full 2·HOLD+1 sequence. Prescale 12 → o_cfg_err pulses one cycle and ratio stays 1.
- Direct write equal to current ratio (4 after 4) → o_busy stays 0 and o_clk_en stays 1.
- I_cfg_valid held during busy with a second value 10 → accepted only at the first IDLE edge; the final ratio is 10 after the second sequence.
- I_rst pulsed while in RESUME → all outputs return to reset values immediately. The staged ratio is lost and ready = 1 after release.
